// File: rtl/controle_varredura_servo.sv
// Ping-pong position sweeper for controle_servo: walks posicao 0..7..0 holding each for M cycles.
// Latency: position period M+1 cycles (M dwell in ESPERA + 1 in MUDA); new posicao visible the cycle after pronto.
// No backpressure: pausar freezes the dwell timer, ligar=0 returns to idle from any state but MUDA.
//
// Ports:
//   clock      in   system clock (50 MHz)
//   reset      in   asynchronous active-high reset
//   ligar      in   level, 1 = sweep enabled, 0 = return to idle
//   pausar     in   level, 1 = freeze dwell timer and hold position
//   posicao    out  [2:0] registered position code for controle_servo
//   sentido    out  registered sweep direction (1 = increasing)
//   pronto     out  one-cycle pulse while the position is being changed
//   db_estado  out  [3:0] FSM state code, zero-extended, for debug
module controle_varredura_servo #(
   parameter int M = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       pausar,
   output logic [2:0] posicao,
   output logic       sentido,
   output logic       pronto,
   output logic [3:0] db_estado
);

   localparam int TW = $clog2(M);
   localparam logic [TW-1:0] TIMER_MAX = TW'(M - 1);

   typedef enum logic [1:0] {
      INICIAL = 2'd0,
      ESPERA  = 2'd1,
      PAUSA   = 2'd2,
      MUDA    = 2'd3
   } estado_t;

   estado_t       estado, estado_prox;
   logic [TW-1:0] timer, timer_prox;
   logic [2:0]    posicao_prox;
   logic          sentido_prox;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado  <= INICIAL;
         timer   <= '0;
         posicao <= 3'd0;
         sentido <= 1'b1;
      end else begin
         estado  <= estado_prox;
         timer   <= timer_prox;
         posicao <= posicao_prox;
         sentido <= sentido_prox;
      end
   end

   always_comb begin
      estado_prox  = estado;
      timer_prox   = timer;
      posicao_prox = posicao;
      sentido_prox = sentido;
      pronto       = 1'b0;

      case (estado)
         INICIAL: begin
            timer_prox   = '0;
            posicao_prox = 3'd0;
            sentido_prox = 1'b1;
            if (ligar)
               estado_prox = ESPERA;
         end

         ESPERA: begin
            if (!ligar) begin
               estado_prox = INICIAL;
            end else if (pausar) begin
               // timer keeps its value so the dwell resumes where it stopped
               estado_prox = PAUSA;
            end else if (timer == TIMER_MAX) begin
               // clear on the way into MUDA: the timer never passes M-1
               estado_prox = MUDA;
               timer_prox  = '0;
            end else begin
               timer_prox = timer + TW'(1);
            end
         end

         PAUSA: begin
            if (!ligar)
               estado_prox = INICIAL;
            else if (!pausar)
               estado_prox = ESPERA;
         end

         MUDA: begin
            // ligar/pausar deliberately ignored for this single cycle
            pronto      = 1'b1;
            timer_prox  = '0;
            estado_prox = ESPERA;
            // endpoints bounce without repeating the end position
            if (sentido) begin
               if (posicao == 3'd7) begin
                  posicao_prox = 3'd6;
                  sentido_prox = 1'b0;
               end else begin
                  posicao_prox = posicao + 3'd1;
               end
            end else begin
               if (posicao == 3'd0) begin
                  posicao_prox = 3'd1;
                  sentido_prox = 1'b1;
               end else begin
                  posicao_prox = posicao - 3'd1;
               end
            end
         end

         default: estado_prox = INICIAL;
      endcase

      // leaving to idle from any state lands on position 0, increasing
      if (estado_prox == INICIAL) begin
         timer_prox   = '0;
         posicao_prox = 3'd0;
         sentido_prox = 1'b1;
      end
   end

   assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed bench for controle_varredura_servo with M=10 (position period 11 cycles).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_controle_varredura_servo;

   logic       clock;
   logic       reset;
   logic       ligar;
   logic       pausar;
   logic [2:0] posicao;
   logic       sentido;
   logic       pronto;
   logic [3:0] db_estado;

   int vetores = 0;
   int erros   = 0;
   int n;

   controle_varredura_servo #(.M(10)) dut (
      .clock     (clock),
      .reset     (reset),
      .ligar     (ligar),
      .pausar    (pausar),
      .posicao   (posicao),
      .sentido   (sentido),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   always #10 clock = ~clock;

   task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      vetores++;
      if (obs !== esp) begin
         erros++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   // counts falling edges until pronto is seen (bounded at 50)
   task automatic espera_pronto(output int cnt);
      cnt = 0;
      do begin
         @(negedge clock);
         cnt++;
      end while (!pronto && cnt < 50);
   endtask

   // {db_estado, posicao, sentido, pronto}
   function automatic logic [8:0] estado_saidas();
      return {db_estado, posicao, sentido, pronto};
   endfunction

   logic [2:0] seq_pos [15] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
   logic       seq_sen [15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [2:0] seq_pos2 [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5};
   logic       seq_sen2 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      clock  = 1'b0;
      reset  = 1'b0;
      ligar  = 1'b0;
      pausar = 1'b0;

      // asynchronous reset takes effect without a clock edge
      #2 reset = 1'b1;
      #1 confere("reset_async", estado_saidas(), {4'd0, 3'd0, 1'b1, 1'b0});
      @(negedge clock);
      reset = 1'b0;

      // idle with ligar=0
      repeat (20) begin
         @(negedge clock);
         confere("ocioso", estado_saidas(), {4'd0, 3'd0, 1'b1, 1'b0});
      end

      // full ping-pong sweep: first change 11 cycles after ligar, then every 11
      ligar = 1'b1;
      for (int i = 0; i < 15; i++) begin
         espera_pronto(n);
         // first wait starts at the ligar edge; later waits start one cycle after the previous pronto
         confere("intervalo_pronto", n, (i == 0) ? 11 : 10);
         confere("pos_durante_muda", posicao, (i == 0) ? 3'd0 : seq_pos[i-1]);
         @(negedge clock);
         confere("seq_posicao", posicao, seq_pos[i]);
         confere("seq_sentido", sentido, seq_sen[i]);
         confere("pronto_1ciclo", pronto, 1'b0);
      end

      // now ESPERA with timer=0, posicao=1; pause when timer reaches 4
      repeat (4) @(negedge clock);
      pausar = 1'b1;
      repeat (25) begin
         @(negedge clock);
         confere("pausa_congelada", {db_estado, posicao, pronto}, {4'd2, 3'd1, 1'b0});
      end
      pausar = 1'b0;
      // release edge -> timer 4..9 (6 cycles) -> MUDA; counted from the release negedge = 7
      espera_pronto(n);
      confere("pronto_pos_pausa", n, 7);
      @(negedge clock);
      confere("pos_pos_pausa", posicao, 3'd2);

      // pause exactly when timer==M-1: PAUSA wins over MUDA
      repeat (9) @(negedge clock);
      pausar = 1'b1;
      repeat (3) begin
         @(negedge clock);
         confere("pausa_no_limite", {db_estado, posicao, pronto}, {4'd2, 3'd2, 1'b0});
      end
      pausar = 1'b0;
      espera_pronto(n);
      confere("pronto_apos_limite", n, 2);
      @(negedge clock);
      confere("pos_apos_limite", posicao, 3'd3);

      // advance to posicao=5 descending
      for (int i = 0; i < 6; i++) begin
         espera_pronto(n);
         confere("intervalo_pronto2", n, 10);
         @(negedge clock);
         confere("seq2_posicao", posicao, seq_pos2[i]);
         confere("seq2_sentido", sentido, seq_sen2[i]);
      end

      // ligar=0 mid-sweep returns to idle at the next edge
      ligar = 1'b0;
      @(negedge clock);
      confere("desliga", estado_saidas(), {4'd0, 3'd0, 1'b1, 1'b0});
      ligar = 1'b1;
      espera_pronto(n);
      confere("religa_latencia", n, 11);
      @(negedge clock);
      confere("religa_posicao", {posicao, sentido}, {3'd1, 1'b1});

      // reset asserted while in MUDA clears outputs before any clock edge
      espera_pronto(n);
      confere("ate_muda", n, 10);
      confere("em_muda", {db_estado, pronto}, {4'd3, 1'b1});
      #1 reset = 1'b1;
      #1 confere("reset_em_muda", {db_estado, posicao, pronto}, {4'd0, 3'd0, 1'b0});
      @(negedge clock);
      reset = 1'b0;
      #1 confere("apos_reset", estado_saidas(), {4'd0, 3'd0, 1'b1, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
      $finish;
   end

endmodule
